// File: rtl/rot_pkg.sv
// Shared definitions for the rotator command sequencer:
// opcodes, command word layout and FSM state encoding.
package rot_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_ROTR = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  // Command word: {op, amt, data, rep}
  localparam int CMD_W    = 15;
  localparam int REP_LSB  = 0;
  localparam int DATA_LSB = 2;
  localparam int AMT_LSB  = 10;
  localparam int OP_LSB   = 13;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  function automatic logic [CMD_W-1:0] pack_cmd(
    input logic [1:0] op,
    input logic [2:0] amt,
    input logic [7:0] data,
    input logic [1:0] rep
  );
    return {op, amt, data, rep};
  endfunction

endpackage

// File: rtl/rot_cmd_fifo.sv
// Four-entry register FIFO holding packed rotator commands.
// Full/empty come from the occupancy counter; pointers just wrap.
module rot_cmd_fifo
  import rot_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [CMD_W-1:0] wdata,
  output logic [CMD_W-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [2:0]       level
);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [1:0]       wp;
  logic [1:0]       rp;

  assign rdata = mem[rp];
  assign full  = (level == 3'(DEPTH));
  assign empty = (level == 3'd0);

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= 2'd0;
      rp    <= 2'd0;
      level <= 3'd0;
    end else if (flush) begin
      wp    <= 2'd0;
      rp    <= 2'd0;
      level <= 3'd0;
    end else begin
      if (push) wp <= wp + 2'd1;
      if (pop)  rp <= rp + 2'd1;
      level <= level + 3'(push) - 3'(pop);
    end
  end

endmodule

// File: rtl/rot_cmd_sequencer.sv
// Queues rotator commands and replays them onto c/s/i with a
// fixed number of hold cycles after every issue.
module rot_cmd_sequencer
  import rot_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_amt,
  input  logic [7:0] cmd_data,
  input  logic [1:0] cmd_rep,
  input  logic       flush,
  output logic [1:0] c,
  output logic [2:0] s,
  output logic [7:0] i,
  output logic       busy,
  output logic       cmd_done,
  output logic [2:0] level
);

  localparam bit NO_GAP = (GAP_CYCLES == 0);
  localparam logic [2:0] GAP_LD =
    NO_GAP ? 3'd0 : 3'(GAP_CYCLES - 1);

  state_t           state;
  logic [1:0]       cur_op;
  logic [1:0]       rep_cnt;
  logic [2:0]       gap_cnt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             last_slot;
  logic [CMD_W-1:0] head;
  logic [1:0]       h_op;
  logic [2:0]       h_amt;
  logic [7:0]       h_data;
  logic [1:0]       h_rep;

  assign cmd_ready = !full && !flush && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (state != S_IDLE) || !empty;

  assign h_op   = head[OP_LSB +: 2];
  assign h_amt  = head[AMT_LSB +: 3];
  assign h_data = head[DATA_LSB +: 8];
  assign h_rep  = head[REP_LSB +: 2];

  // Final cycle of the current issue slot (issue plus its gap)
  always_comb begin
    last_slot = 1'b0;
    if (state == S_ISSUE && NO_GAP)   last_slot = 1'b1;
    if (state == S_GAP && gap_cnt == 3'd0) last_slot = 1'b1;
    pop = !flush && !empty &&
          (state == S_IDLE || (last_slot && rep_cnt == 2'd0));
  end

  rot_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (pack_cmd(cmd_op, cmd_amt, cmd_data, cmd_rep)),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cur_op   <= OP_HOLD;
      rep_cnt  <= 2'd0;
      gap_cnt  <= 3'd0;
      c        <= OP_HOLD;
      s        <= 3'd0;
      i        <= 8'h00;
      cmd_done <= 1'b0;
    end else if (flush) begin
      state    <= S_IDLE;
      c        <= OP_HOLD;
      cmd_done <= 1'b0;
    end else if (pop) begin
      state    <= S_ISSUE;
      cur_op   <= h_op;
      rep_cnt  <= h_rep;
      c        <= h_op;
      s        <= h_amt;
      i        <= h_data;
      cmd_done <= NO_GAP && (h_rep == 2'd0);
    end else if (last_slot && rep_cnt != 2'd0) begin
      state    <= S_ISSUE;
      rep_cnt  <= rep_cnt - 2'd1;
      c        <= cur_op;
      cmd_done <= NO_GAP && (rep_cnt == 2'd1);
    end else if (last_slot) begin
      state    <= S_IDLE;
      c        <= OP_HOLD;
      cmd_done <= 1'b0;
    end else if (state == S_ISSUE) begin
      state    <= S_GAP;
      gap_cnt  <= GAP_LD;
      c        <= OP_HOLD;
      cmd_done <= (GAP_LD == 3'd0) && (rep_cnt == 2'd0);
    end else if (state == S_GAP) begin
      gap_cnt  <= gap_cnt - 3'd1;
      cmd_done <= (gap_cnt == 3'd1) && (rep_cnt == 2'd0);
    end else begin
      c        <= OP_HOLD;
      cmd_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rot_cmd_sequencer.sv
// Drives two sequencers (gap 2 and gap 0) with shared stimulus and
// compares every output against a per-command slot-timeline model.
module tb_rot_cmd_sequencer;
  import rot_pkg::*;

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] amt;
    logic [7:0] data;
    logic [1:0] rep;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [2:0] cmd_amt = 3'd0;
  logic [7:0] cmd_data = 8'd0;
  logic [1:0] cmd_rep = 2'd0;

  logic       rdy   [2];
  logic [1:0] c_o   [2];
  logic [2:0] s_o   [2];
  logic [7:0] i_o   [2];
  logic       busy_o[2];
  logic       done_o[2];
  logic [2:0] lvl_o [2];

  int n_chk = 0;
  int n_pass = 0;

  int         gp  [2];
  cmd_t       mq  [2][4];
  int         mcnt[2];
  bit         act [2];
  cmd_t       cur [2];
  int         k   [2];
  int         tot [2];
  logic [2:0] se  [2];
  logic [7:0] ie  [2];
  bit         psh [2];

  always #5 clk = ~clk;

  rot_cmd_sequencer #(.GAP_CYCLES(2), .DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy[0]),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data),
    .cmd_rep(cmd_rep), .flush(flush), .c(c_o[0]), .s(s_o[0]),
    .i(i_o[0]), .busy(busy_o[0]), .cmd_done(done_o[0]),
    .level(lvl_o[0])
  );

  rot_cmd_sequencer #(.GAP_CYCLES(0), .DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy[1]),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data),
    .cmd_rep(cmd_rep), .flush(flush), .c(c_o[1]), .s(s_o[1]),
    .i(i_o[1]), .busy(busy_o[1]), .cmd_done(done_o[1]),
    .level(lvl_o[1])
  );

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0;
      act[d]  = 1'b0;
      cur[d]  = '0;
      k[d]    = 0;
      tot[d]  = 1;
      se[d]   = 3'd0;
      ie[d]   = 8'h00;
    end
  endtask

  // Each command occupies (rep+1)*(gap+1) cycles; issues sit on slot starts
  task automatic model_edge(input int d, input bit p, input bit fl,
                            input cmd_t nc);
    if (fl) begin
      mcnt[d] = 0;
      act[d]  = 1'b0;
      return;
    end
    if (!act[d] || k[d] == tot[d] - 1) begin
      if (mcnt[d] > 0) begin
        cur[d] = mq[d][0];
        for (int j = 0; j < 3; j++) mq[d][j] = mq[d][j+1];
        mcnt[d]--;
        act[d] = 1'b1;
        k[d]   = 0;
        tot[d] = (int'(cur[d].rep) + 1) * (gp[d] + 1);
        se[d]  = cur[d].amt;
        ie[d]  = cur[d].data;
      end else begin
        act[d] = 1'b0;
      end
    end else begin
      k[d]++;
    end
    if (p) begin
      mq[d][mcnt[d]] = nc;
      mcnt[d]++;
    end
  endtask

  task automatic check_outs(input int d);
    logic [1:0] c_e;
    c_e = (act[d] && (k[d] % (gp[d] + 1)) == 0) ? cur[d].op : OP_HOLD;
    check($sformatf("c[%0d]", d), 8'(c_o[d]), 8'(c_e));
    check($sformatf("s[%0d]", d), 8'(s_o[d]), 8'(se[d]));
    check($sformatf("i[%0d]", d), i_o[d], ie[d]);
    check($sformatf("busy[%0d]", d), 8'(busy_o[d]),
          8'(act[d] || mcnt[d] > 0));
    check($sformatf("done[%0d]", d), 8'(done_o[d]),
          8'(act[d] && k[d] == tot[d] - 1));
    check($sformatf("level[%0d]", d), 8'(lvl_o[d]), 8'(mcnt[d]));
  endtask

  task automatic step(input bit v, input cmd_t nc, input bit fl);
    @(negedge clk);
    cmd_valid = v;
    cmd_op    = nc.op;
    cmd_amt   = nc.amt;
    cmd_data  = nc.data;
    cmd_rep   = nc.rep;
    flush     = fl;
    #1;
    for (int d = 0; d < 2; d++) begin
      psh[d] = v && (mcnt[d] < 4) && !fl;
      check($sformatf("ready[%0d]", d), 8'(rdy[d]),
            8'((mcnt[d] < 4) && !fl));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d, psh[d], fl, nc);
    #1;
    for (int d = 0; d < 2; d++) check_outs(d);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, '0, 1'b0);
  endtask

  function automatic cmd_t rnd_cmd();
    return cmd_t'(15'($urandom()));
  endfunction

  initial begin
    int w;
    gp[0] = 2;
    gp[1] = 0;
    model_reset();

    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_outs(d);
      check($sformatf("ready_rst[%0d]", d), 8'(rdy[d]), 8'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, '{OP_LOAD, 3'd0, 8'hA5, 2'd0}, 1'b0);
    idle(6);

    step(1'b1, '{OP_SHL, 3'd3, 8'h3C, 2'd2}, 1'b0);
    idle(12);

    step(1'b1, '{OP_ROTR, 3'd2, 8'h11, 2'd1}, 1'b0);
    step(1'b1, '{OP_SHL, 3'd5, 8'h22, 2'd0}, 1'b0);
    step(1'b1, '{OP_HOLD, 3'd7, 8'h33, 2'd1}, 1'b0);
    step(1'b1, '{OP_LOAD, 3'd1, 8'h44, 2'd0}, 1'b0);
    step(1'b1, '{OP_ROTR, 3'd6, 8'h55, 2'd3}, 1'b0);
    step(1'b1, '{OP_SHL, 3'd4, 8'h66, 2'd0}, 1'b0);
    idle(40);

    step(1'b1, '{OP_ROTR, 3'd1, 8'h77, 2'd0}, 1'b0);
    step(1'b1, '{OP_ROTR, 3'd1, 8'h88, 2'd0}, 1'b0);
    idle(8);

    step(1'b1, '{OP_LOAD, 3'd2, 8'h99, 2'd1}, 1'b0);
    step(1'b1, '{OP_SHL, 3'd3, 8'hAA, 2'd1}, 1'b0);
    step(1'b1, '{OP_ROTR, 3'd4, 8'hBB, 2'd1}, 1'b0);
    step(1'b1, '{OP_LOAD, 3'd5, 8'hCC, 2'd1}, 1'b0);
    idle(1);
    step(1'b1, '{OP_SHL, 3'd6, 8'hDD, 2'd0}, 1'b1);
    step(1'b1, '{OP_LOAD, 3'd7, 8'hEE, 2'd0}, 1'b0);
    idle(10);

    for (int j = 0; j < 300; j++) begin
      step($urandom_range(0, 99) < 60, rnd_cmd(),
           $urandom_range(0, 99) < 3);
    end
    idle(40);

    step(1'b1, '{OP_SHL, 3'd2, 8'h5A, 2'd3}, 1'b0);
    w = 0;
    while (c_o[0] == OP_HOLD && w < 20) begin
      step(1'b0, '0, 1'b0);
      w++;
    end
    check("issue_wait", 8'(w < 20), 8'd1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      check_outs(d);
      check($sformatf("ready_arst[%0d]", d), 8'(rdy[d]), 8'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    step(1'b1, '{OP_LOAD, 3'd0, 8'hC3, 2'd0}, 1'b0);
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
